// File: rtl/int_to_ascii_tx.sv
// int_to_ascii_tx: converts one binary integer to its ASCII decimal string
// and streams it MSB digit first, with an optional leading '-'. The binary
// to BCD step is a serial double-dabble (shift-add-3), one bit per cycle.
module int_to_ascii_tx #(
   parameter int DATA_W = 32,
   parameter bit SIGNED = 1'b1,
   parameter int NDIG   = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        out_char,
   output logic              out_last,
   output logic              busy
);

   localparam int BCD_W = 4 * NDIG;
   localparam int CNT_W = $clog2(DATA_W);
   localparam int IDX_W = $clog2(NDIG);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CONV = 3'd1,
      ST_PREP = 3'd2,
      ST_SIGN = 3'd3,
      ST_EMIT = 3'd4
   } state_t;

   // Add 3 to every BCD nibble that is 5 or more (pre-shift correction).
   function automatic logic [BCD_W-1:0] add3_all(input logic [BCD_W-1:0] b);
      logic [BCD_W-1:0] r;
      r = b;
      for (int i = 0; i < NDIG; i++) begin
         if (b[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = b[4*i +: 4] + 4'd3;
         end else begin
            r[4*i +: 4] = b[4*i +: 4];
         end
      end
      return r;
   endfunction

   // Position of the most significant nonzero digit; 0 for an all-zero value.
   function automatic logic [IDX_W-1:0] msd_idx(input logic [BCD_W-1:0] b);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int i = 0; i < NDIG; i++) begin
         if (b[4*i +: 4] != 4'd0) begin
            r = IDX_W'(i);
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

   // ASCII character for the BCD digit at position idx.
   function automatic logic [7:0] digit_char(input logic [BCD_W-1:0] b,
                                             input logic [IDX_W-1:0] idx);
      logic [3:0] d;
      d = 4'(b >> (4 * int'(idx)));
      return 8'h30 + {4'h0, d};
   endfunction

   state_t            state_r;
   logic [DATA_W-1:0] mag_r;
   logic [BCD_W-1:0]  bcd_r;
   logic [CNT_W-1:0]  cnt_r;
   logic [IDX_W-1:0]  idx_r;
   logic              neg_r;
   logic              in_ready_r;
   logic              out_valid_r;
   logic [7:0]        out_char_r;
   logic              out_last_r;
   logic              busy_r;

   logic              neg_in_s;
   logic [DATA_W-1:0] mag_in_s;
   logic [BCD_W-1:0]  bcd_adj_s;
   logic [IDX_W-1:0]  msd_s;

   // Sign/magnitude of the incoming value and per-cycle BCD helpers.
   always_comb begin
      neg_in_s  = SIGNED && in_data[DATA_W-1];
      if (neg_in_s) begin
         mag_in_s = ~in_data + {{(DATA_W-1){1'b0}}, 1'b1};
      end else begin
         mag_in_s = in_data;
      end
      bcd_adj_s = add3_all(bcd_r);
      msd_s     = msd_idx(bcd_r);
   end

   // Main FSM: capture, serial conversion, digit search, then streaming.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         mag_r       <= '0;
         bcd_r       <= '0;
         cnt_r       <= '0;
         idx_r       <= '0;
         neg_r       <= 1'b0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         out_char_r  <= 8'h00;
         out_last_r  <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (in_valid && in_ready_r) begin
                  neg_r      <= neg_in_s;
                  mag_r      <= mag_in_s;
                  bcd_r      <= '0;
                  cnt_r      <= '0;
                  in_ready_r <= 1'b0;
                  busy_r     <= 1'b1;
                  state_r    <= ST_CONV;
               end
            end
            ST_CONV: begin
               bcd_r <= {bcd_adj_s[BCD_W-2:0], mag_r[DATA_W-1]};
               mag_r <= {mag_r[DATA_W-2:0], 1'b0};
               cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
               if (cnt_r == CNT_W'(DATA_W - 1)) begin
                  state_r <= ST_PREP;
               end
            end
            ST_PREP: begin
               idx_r       <= msd_s;
               out_valid_r <= 1'b1;
               if (neg_r) begin
                  out_char_r <= 8'h2D;
                  out_last_r <= 1'b0;
                  state_r    <= ST_SIGN;
               end else begin
                  out_char_r <= digit_char(bcd_r, msd_s);
                  out_last_r <= (msd_s == {IDX_W{1'b0}});
                  state_r    <= ST_EMIT;
               end
            end
            ST_SIGN: begin
               if (out_ready) begin
                  out_char_r <= digit_char(bcd_r, idx_r);
                  out_last_r <= (idx_r == {IDX_W{1'b0}});
                  state_r    <= ST_EMIT;
               end
            end
            ST_EMIT: begin
               if (out_ready) begin
                  if (idx_r == {IDX_W{1'b0}}) begin
                     out_valid_r <= 1'b0;
                     out_char_r  <= 8'h00;
                     out_last_r  <= 1'b0;
                     in_ready_r  <= 1'b1;
                     busy_r      <= 1'b0;
                     state_r     <= ST_IDLE;
                  end else begin
                     idx_r      <= idx_r - {{(IDX_W-1){1'b0}}, 1'b1};
                     out_char_r <= digit_char(bcd_r, idx_r - {{(IDX_W-1){1'b0}}, 1'b1});
                     out_last_r <= (idx_r == {{(IDX_W-1){1'b0}}, 1'b1});
                  end
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
               out_char_r  <= 8'h00;
               out_last_r  <= 1'b0;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_char  = out_char_r;
   assign out_last  = out_last_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_int_to_ascii_tx.sv
// Bench for int_to_ascii_tx: a signed and an unsigned instance, strings
// predicted with $sformatf decimal formatting of the input value.
module tb_int_to_ascii_tx;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] in_data;
   logic        iv, ordy;
   bit          sel;  // 0: signed instance, 1: unsigned instance

   logic        s_iv, s_ir, s_ov, s_or, s_ol, s_busy;
   logic        u_iv, u_ir, u_ov, u_or, u_ol, u_busy;
   logic [7:0]  s_oc, u_oc;
   logic        ir, ov, ol, busy;
   logic [7:0]  oc;

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   assign s_iv = !sel && iv;
   assign u_iv = sel && iv;
   assign s_or = !sel && ordy;
   assign u_or = sel && ordy;
   assign ir   = sel ? u_ir : s_ir;
   assign ov   = sel ? u_ov : s_ov;
   assign ol   = sel ? u_ol : s_ol;
   assign oc   = sel ? u_oc : s_oc;
   assign busy = sel ? u_busy : s_busy;

   int_to_ascii_tx #(.DATA_W(32), .SIGNED(1'b1), .NDIG(10)) u_sgn (
      .clk(clk), .rst_n(rst_n), .in_valid(s_iv), .in_ready(s_ir), .in_data(in_data),
      .out_valid(s_ov), .out_ready(s_or), .out_char(s_oc), .out_last(s_ol), .busy(s_busy));

   int_to_ascii_tx #(.DATA_W(32), .SIGNED(1'b0), .NDIG(10)) u_uns (
      .clk(clk), .rst_n(rst_n), .in_valid(u_iv), .in_ready(u_ir), .in_data(in_data),
      .out_valid(u_ov), .out_ready(u_or), .out_char(u_oc), .out_last(u_ol), .busy(u_busy));

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // Convert one value and check latency, every character, stall holding and return to idle.
   // mode 0: out_ready always 1, mode 1: pattern 1,0,0 repeating, mode 2: random.
   task automatic run_string(input logic [31:0] val, input bit uns, input int mode, input string name);
      string      exp;
      int         k, pos, c;
      bit         done, pst, bad;
      logic [7:0] pch;
      logic       pl;
      if (uns) exp = $sformatf("%0d", val);
      else     exp = $sformatf("%0d", $signed(val));
      sel  = uns;
      ordy = 1'b0;
      @(negedge clk);
      vecs++;
      if (ir !== 1'b1) begin
         errs++; $display("FAIL %s in_ready_idle got=%b exp=1", name, ir);
      end
      in_data = val;
      iv      = 1'b1;
      @(negedge clk);
      in_data = ~val;  // held while busy; must be ignored
      k   = 0;
      bad = 1'b0;
      while (ov !== 1'b1 && k < 100) begin
         if (ir !== 1'b0 || busy !== 1'b1) bad = 1'b1;
         @(negedge clk);
         k++;
      end
      iv = 1'b0;
      vecs++;
      if (k != 33) begin
         errs++; $display("FAIL %s latency got=%0d exp=33", name, k);
      end
      vecs++;
      if (bad) begin
         errs++; $display("FAIL %s busy_during_conv in_ready/busy wrong got=1 exp=0", name);
      end
      pos  = 0; c = 0; done = 1'b0; pst = 1'b0; pch = 8'h00; pl = 1'b0;
      while (!done && c < 300) begin
         if (ov !== 1'b1 || ir !== 1'b0) begin
            vecs++; errs++;
            $display("FAIL %s stream_valid got ov=%b ir=%b exp ov=1 ir=0", name, ov, ir);
            done = 1'b1;
         end else begin
            if (pst) begin
               vecs++;
               if (oc !== pch || ol !== pl) begin
                  errs++; $display("FAIL %s stall_hold got=%h/%b exp=%h/%b", name, oc, ol, pch, pl);
               end
            end
            if (mode == 0)      ordy = 1'b1;
            else if (mode == 1) ordy = (c % 3 == 0);
            else                ordy = 1'($urandom_range(0, 1));
            if (ordy) begin
               vecs++;
               if (pos >= exp.len()) begin
                  errs++; $display("FAIL %s extra_char got=%h exp=none", name, oc);
                  done = 1'b1;
               end else if (oc !== exp[pos] || ol !== (pos == exp.len() - 1)) begin
                  errs++;
                  $display("FAIL %s char%0d got=%h last=%b exp=%h last=%b", name, pos, oc, ol,
                           exp[pos], (pos == exp.len() - 1));
               end
               if (ol === 1'b1) done = 1'b1;
               pos++;
            end
            pst = !ordy; pch = oc; pl = ol;
            @(negedge clk);
            c++;
         end
      end
      ordy = 1'b0;
      vecs++;
      if (pos != exp.len()) begin
         errs++; $display("FAIL %s length got=%0d exp=%0d", name, pos, exp.len());
      end
      vecs++;
      if (ir !== 1'b1 || ov !== 1'b0 || busy !== 1'b0) begin
         errs++; $display("FAIL %s return_idle got ir=%b ov=%b busy=%b exp 1/0/0", name, ir, ov, busy);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; iv = 1'b0; ordy = 1'b0; sel = 1'b0; in_data = 32'd0;
      #12;
      vecs++;
      if (s_ir !== 1'b1 || s_ov !== 1'b0 || s_oc !== 8'h00 || s_ol !== 1'b0 || s_busy !== 1'b0) begin
         errs++; $display("FAIL reset_sgn got ir=%b ov=%b oc=%h ol=%b busy=%b exp 1/0/00/0/0",
                          s_ir, s_ov, s_oc, s_ol, s_busy);
      end
      vecs++;
      if (u_ir !== 1'b1 || u_ov !== 1'b0 || u_oc !== 8'h00 || u_ol !== 1'b0 || u_busy !== 1'b0) begin
         errs++; $display("FAIL reset_uns got ir=%b ov=%b oc=%h ol=%b busy=%b exp 1/0/00/0/0",
                          u_ir, u_ov, u_oc, u_ol, u_busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      run_string(32'd0, 1'b0, 0, "zero");
      run_string(32'd12345, 1'b0, 0, "12345");
      run_string(32'hFFFFFFF9, 1'b0, 0, "minus7");
      run_string(32'h80000000, 1'b0, 0, "most_neg");
      run_string(32'hFFFFFFFF, 1'b1, 0, "uns_max");
      run_string(32'd907, 1'b0, 1, "stall907");
   endtask

   task automatic test_reset_mid_stream();
      int k;
      sel = 1'b0; ordy = 1'b0;
      @(negedge clk);
      in_data = 32'd123456; iv = 1'b1;
      @(negedge clk);
      iv = 1'b0;
      k = 0;
      while (s_ov !== 1'b1 && k < 100) begin
         @(negedge clk); k++;
      end
      ordy = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      vecs++;
      if (s_ov !== 1'b0 || s_ir !== 1'b1 || s_busy !== 1'b0 || s_oc !== 8'h00) begin
         errs++; $display("FAIL async_reset got ov=%b ir=%b busy=%b oc=%h exp 0/1/0/00",
                          s_ov, s_ir, s_busy, s_oc);
      end
      ordy = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      vecs++;
      if (s_ov !== 1'b0 || s_ir !== 1'b1) begin
         errs++; $display("FAIL no_resume got ov=%b ir=%b exp 0/1", s_ov, s_ir);
      end
      run_string(32'd42, 1'b0, 0, "after_reset42");
   endtask

   task automatic test_random();
      logic [31:0] v;
      for (int i = 0; i < 10; i++) begin
         case (i % 3)
            0:       v = $urandom;
            1:       v = 32'($urandom_range(0, 99));
            default: v = -32'($urandom_range(1, 1000));
         endcase
         run_string(v, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $sformatf("rand%0d", i));
      end
   endtask

   task automatic test_back_to_back();
      run_string(32'd9, 1'b0, 0, "b2b_a");
      run_string(32'd1000000000, 1'b0, 0, "b2b_b");
      run_string(32'd10, 1'b1, 2, "b2b_c");
   endtask

   initial begin
      test_reset();
      test_directed();
      test_reset_mid_stream();
      test_random();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
